// File: rtl/ps2_synth_pkg.sv
// Shared definitions for the PS/2 synth front end: the scancodes, the note index
// type, the decoder prefix states, and the scancode-to-note map.
package ps2_synth_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_NOTE0  = 8'h1C;
    localparam logic [7:0] SC_NOTE1  = 8'h1D;
    localparam logic [7:0] SC_NOTE2  = 8'h1B;
    localparam logic [7:0] SC_NOTE3  = 8'h24;
    localparam logic [7:0] SC_NOTE4  = 8'h2B;
    localparam logic [7:0] SC_NOTE5  = 8'h23;
    localparam logic [7:0] SC_NOTE6  = 8'h2C;
    localparam logic [7:0] SC_NOTE7  = 8'h34;
    localparam logic [7:0] SC_NOTE8  = 8'h35;
    localparam logic [7:0] SC_NOTE9  = 8'h33;
    localparam logic [7:0] SC_NOTE10 = 8'h3C;
    localparam logic [7:0] SC_NOTE11 = 8'h3B;
    localparam logic [7:0] SC_NOTE12 = 8'h42;

    typedef logic [3:0] note_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic  hit;
        note_t note;
    } scan_map_t;

    function automatic scan_map_t map_scancode(input logic [7:0] code);
        scan_map_t m;
        m.hit  = 1'b1;
        m.note = '0;
        case (code)
            SC_NOTE0:  m.note = 4'd0;
            SC_NOTE1:  m.note = 4'd1;
            SC_NOTE2:  m.note = 4'd2;
            SC_NOTE3:  m.note = 4'd3;
            SC_NOTE4:  m.note = 4'd4;
            SC_NOTE5:  m.note = 4'd5;
            SC_NOTE6:  m.note = 4'd6;
            SC_NOTE7:  m.note = 4'd7;
            SC_NOTE8:  m.note = 4'd8;
            SC_NOTE9:  m.note = 4'd9;
            SC_NOTE10: m.note = 4'd10;
            SC_NOTE11: m.note = 4'd11;
            SC_NOTE12: m.note = 4'd12;
            default:   m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_voice_scheduler_if.sv
// Byte input and voice-control outputs of the scheduler, bundled for the
// receiver side (master) and the scheduler (slave).
interface ps2_voice_scheduler_if #(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2
);
    logic [7:0]              received_data;
    logic                    received_data_en;
    logic [NUM_VOICES-1:0]   voice_active;
    logic [4*NUM_VOICES-1:0] voice_note;
    logic                    note_on;
    logic                    note_off;
    logic [VIDX_W-1:0]       event_voice;
    logic [3:0]              event_note;

    modport master (
        output received_data, received_data_en,
        input  voice_active, voice_note, note_on, note_off, event_voice, event_note
    );

    modport slave (
        input  received_data, received_data_en,
        output voice_active, voice_note, note_on, note_off, event_voice, event_note
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Prefix FSM (F0 / E0 handling) and scancode map. The prefix state is registered;
// make/break events are combinational from the byte that completes a sequence.
module ps2_scancode_decoder
    import ps2_synth_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_en,
    output logic       make_valid,
    output logic       break_valid,
    output note_t      note
);

    dec_state_e state_q, state_d;
    scan_map_t  map;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value held (no latch).
    always_comb begin
        state_d     = state_q;
        make_valid  = 1'b0;
        break_valid = 1'b0;
        map         = map_scancode(data);
        note        = map.note;
        if (data_en) begin
            case (state_q)
                IDLE: begin
                    if (data == SC_BREAK)    state_d = BRK;
                    else if (data == SC_EXT) state_d = EXT;
                    else if (map.hit)        make_valid = 1'b1;
                end
                BRK: begin
                    if (map.hit) begin
                        break_valid = 1'b1;
                        state_d     = IDLE;
                    end else if (data == SC_EXT) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                // Extended keys are not part of the keyboard map; their codes are swallowed.
                EXT:     state_d = (data == SC_BREAK) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

endmodule

// File: rtl/ps2_voice_scheduler.sv
// Turns decoded make/break events into voice allocations: a lowest-free-first
// allocator with round-robin stealing when every voice is busy.
module ps2_voice_scheduler
    import ps2_synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2
) (
    input  logic CLOCK_50,
    input  logic reset,
    ps2_voice_scheduler_if.slave bus
);

    logic  make_valid;
    logic  break_valid;
    note_t dec_note;

    ps2_scancode_decoder u_decoder (
        .clk         (CLOCK_50),
        .rst_n       (reset),
        .data        (bus.received_data),
        .data_en     (bus.received_data_en),
        .make_valid  (make_valid),
        .break_valid (break_valid),
        .note        (dec_note)
    );

    logic [NUM_VOICES-1:0] voice_active_q, voice_active_d;
    note_t                 voice_note_q [NUM_VOICES];
    note_t                 voice_note_d [NUM_VOICES];
    logic [VIDX_W-1:0]     steal_ptr_q, steal_ptr_d;
    logic                  note_on_q, note_on_d;
    logic                  note_off_q, note_off_d;
    logic [VIDX_W-1:0]     event_voice_q, event_voice_d;
    note_t                 event_note_q, event_note_d;

    logic              match_found;
    logic [VIDX_W-1:0] match_idx;
    logic              free_found;
    logic [VIDX_W-1:0] free_idx;

    // Descending scan so the lowest-index candidate is the one left standing.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_active_q[i] && voice_note_q[i] == dec_note) begin
                match_found = 1'b1;
                match_idx   = VIDX_W'(i);
            end
            if (!voice_active_q[i]) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(i);
            end
        end
    end

    always_comb begin
        voice_active_d = voice_active_q;
        voice_note_d   = voice_note_q;
        steal_ptr_d    = steal_ptr_q;
        note_on_d      = 1'b0;
        note_off_d     = 1'b0;
        event_voice_d  = event_voice_q;
        event_note_d   = event_note_q;

        if (make_valid && !match_found) begin
            note_on_d    = 1'b1;
            event_note_d = dec_note;
            if (free_found) begin
                voice_active_d[free_idx] = 1'b1;
                voice_note_d[free_idx]   = dec_note;
                event_voice_d            = free_idx;
            end else begin
                voice_note_d[steal_ptr_q] = dec_note;
                event_voice_d             = steal_ptr_q;
                steal_ptr_d = (steal_ptr_q == VIDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
            end
        end else if (break_valid && match_found) begin
            voice_active_d[match_idx] = 1'b0;
            note_off_d                = 1'b1;
            event_voice_d             = match_idx;
            event_note_d              = dec_note;
        end
    end

    // NOTE: the small per-voice note array is reset along with the control flops
    // because it drives outputs that must read zero out of reset.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            voice_active_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) voice_note_q[i] <= '0;
            steal_ptr_q    <= '0;
            note_on_q      <= 1'b0;
            note_off_q     <= 1'b0;
            event_voice_q  <= '0;
            event_note_q   <= '0;
        end else begin
            voice_active_q <= voice_active_d;
            voice_note_q   <= voice_note_d;
            steal_ptr_q    <= steal_ptr_d;
            note_on_q      <= note_on_d;
            note_off_q     <= note_off_d;
            event_voice_q  <= event_voice_d;
            event_note_q   <= event_note_d;
        end
    end

    always_comb begin
        bus.voice_note = '0;
        for (int i = 0; i < NUM_VOICES; i++) bus.voice_note[4*i +: 4] = voice_note_q[i];
    end

    assign bus.voice_active = voice_active_q;
    assign bus.note_on      = note_on_q;
    assign bus.note_off     = note_off_q;
    assign bus.event_voice  = event_voice_q;
    assign bus.event_note   = event_note_q;

endmodule

// File: tb/tb_ps2_voice_scheduler.sv
// Directed bench for ps2_voice_scheduler: byte sequences with hand-computed
// voice states and event pulses, sampled on the falling clock edge.
module tb_ps2_voice_scheduler;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ps2_voice_scheduler_if #(.NUM_VOICES(4), .VIDX_W(2)) bus ();

    ps2_voice_scheduler #(.NUM_VOICES(4), .VIDX_W(2)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe one byte for one cycle; returns on the falling edge after the
    // sampling edge, when the resulting pulse is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.received_data    = b;
        bus.received_data_en = 1'b1;
        @(negedge clk);
        bus.received_data_en = 1'b0;
    endtask

    task automatic expect_ev(input string tag, input logic on, input logic off,
                             input logic [1:0] ev, input logic [3:0] en);
        check({tag, ".on"},  32'(bus.note_on),  32'(on));
        check({tag, ".off"}, 32'(bus.note_off), 32'(off));
        if (on || off) begin
            check({tag, ".voice"}, 32'(bus.event_voice), 32'(ev));
            check({tag, ".note"},  32'(bus.event_note),  32'(en));
        end
    endtask

    task automatic expect_voices(input string tag, input logic [3:0] act, input logic [15:0] notes);
        check({tag, ".active"}, 32'(bus.voice_active), 32'(act));
        check({tag, ".notes"},  32'(bus.voice_note),   32'(notes));
    endtask

    task automatic expect_all_zero(input string tag);
        expect_voices(tag, 4'h0, 16'h0000);
        check({tag, ".on"},    32'(bus.note_on),     32'd0);
        check({tag, ".off"},   32'(bus.note_off),    32'd0);
        check({tag, ".voice"}, 32'(bus.event_voice), 32'd0);
        check({tag, ".enote"}, 32'(bus.event_note),  32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #3;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.received_data    = 8'h00;
        bus.received_data_en = 1'b0;
        #25;
        expect_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // First make lands in voice 0, pulse lasts one cycle.
        send(8'h1C);
        expect_voices("mk1c", 4'b0001, 16'h0000);
        expect_ev("mk1c", 1'b1, 1'b0, 2'd0, 4'd0);
        @(negedge clk);
        check("pulse_clear", 32'(bus.note_on), 32'd0);

        // Fill all voices, then steal round-robin.
        send(8'h1D); expect_ev("mk1d", 1'b1, 1'b0, 2'd1, 4'd1);
        send(8'h1B); expect_ev("mk1b", 1'b1, 1'b0, 2'd2, 4'd2);
        send(8'h24); expect_ev("mk24", 1'b1, 1'b0, 2'd3, 4'd3);
        expect_voices("full", 4'b1111, 16'h3210);
        send(8'h2B); expect_ev("steal0", 1'b1, 1'b0, 2'd0, 4'd4);
        expect_voices("steal0", 4'b1111, 16'h3214);
        send(8'h23); expect_ev("steal1", 1'b1, 1'b0, 2'd1, 4'd5);
        expect_voices("steal1", 4'b1111, 16'h3254);
        send(8'h2C); expect_ev("steal2", 1'b1, 1'b0, 2'd2, 4'd6);
        expect_voices("steal2", 4'b1111, 16'h3654);

        // Break of a stolen note does nothing; break of a held one frees it.
        send(8'hF0); send(8'h1C);
        expect_ev("brk_stolen", 1'b0, 1'b0, 2'd0, 4'd0);
        expect_voices("brk_stolen", 4'b1111, 16'h3654);
        send(8'hF0); send(8'h2B);
        expect_ev("brk2b", 1'b0, 1'b1, 2'd0, 4'd4);
        expect_voices("brk2b", 4'b1110, 16'h3654);

        // Free voice is preferred; steal pointer was untouched and then wraps.
        send(8'h34); expect_ev("refill", 1'b1, 1'b0, 2'd0, 4'd7);
        expect_voices("refill", 4'b1111, 16'h3657);
        send(8'h35); expect_ev("steal3", 1'b1, 1'b0, 2'd3, 4'd8);
        expect_voices("steal3", 4'b1111, 16'h8657);
        send(8'h33); expect_ev("steal_wrap", 1'b1, 1'b0, 2'd0, 4'd9);
        expect_voices("steal_wrap", 4'b1111, 16'h8659);

        // Make / break / duplicate break.
        do_reset();
        send(8'h1C);
        send(8'hF0);
        expect_ev("f0_only", 1'b0, 1'b0, 2'd0, 4'd0);
        send(8'h1C);
        expect_ev("brk1c", 1'b0, 1'b1, 2'd0, 4'd0);
        expect_voices("brk1c", 4'b0000, 16'h0000);
        send(8'hF0); send(8'h1C);
        expect_ev("brk_again", 1'b0, 1'b0, 2'd0, 4'd0);

        // Typematic repeat and extended-prefix discard.
        send(8'h1C); expect_ev("typ1", 1'b1, 1'b0, 2'd0, 4'd0);
        send(8'h1C); expect_ev("typ2", 1'b0, 1'b0, 2'd0, 4'd0);
        expect_voices("typ2", 4'b0001, 16'h0000);
        send(8'hE0); send(8'hF0);
        send(8'h1C); expect_ev("ext_brk", 1'b0, 1'b0, 2'd0, 4'd0);
        send(8'h1C); expect_ev("ext_rep", 1'b0, 1'b0, 2'd0, 4'd0);
        expect_voices("ext_rep", 4'b0001, 16'h0000);

        // Unmapped bytes.
        do_reset();
        send(8'h5A); expect_ev("unmap", 1'b0, 1'b0, 2'd0, 4'd0);
        send(8'hF0); send(8'h5A); expect_ev("brk_unmap", 1'b0, 1'b0, 2'd0, 4'd0);
        expect_voices("unmap", 4'b0000, 16'h0000);
        send(8'h1C); expect_ev("after_unmap", 1'b1, 1'b0, 2'd0, 4'd0);
        expect_voices("after_unmap", 4'b0001, 16'h0000);

        // Asynchronous reset mid-sequence clears a pending F0.
        send(8'h3C);
        expect_voices("pre_rst", 4'b0011, 16'h00A0);
        send(8'hF0);
        @(posedge clk);
        #4 reset = 1'b0;
        #1 expect_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;
        send(8'h1C);
        expect_ev("post_rst", 1'b1, 1'b0, 2'd0, 4'd0);
        expect_voices("post_rst", 4'b0001, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
